// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter
//   Shares the data-memory port and the peripheral bus between the CPU datapath
//   and the UART program loader. IO accesses are sequenced through a ready
//   handshake with a bounded wait. The CPU is stalled, or held in reset, while it
//   does not own the shared resources.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   RUN   | CPU owns the RAM port; an IO strobe or a loader request leaves RUN
//   IO_WAIT| io_req held, waiting for io_ready or for the timeout to expire
//   IO_DONE| one cycle where the CPU retires the IO instruction with io_q
//   LOAD  | loader owns the RAM port, CPU held in reset, writes are counted
//   DRAIN | one quiet cycle (CPU still in reset, no RAM write) before RUN
//
// Ports
//   clock, reset                  clock, asynchronous active-high reset
//   cpu_mem_read/write            CPU memory strobes
//   cpu_io_read/write             CPU IO strobes
//   cpu_addr, cpu_wdata           CPU word address / store data
//   cpu_rdata                     load data back to the CPU
//   cpu_stall, cpu_rst            CPU freeze / CPU reset hold
//   upg_req/wen/addr/wdata/done   program loader interface
//   mem_wen/addr/wdata/rdata      data RAM port
//   io_req/we/addr/wdata          peripheral request (latched at the strobe)
//   io_rdata, io_ready            peripheral read data / completion
//   load_count                    loader writes, saturating at 0xFFFF
//   io_err                        sticky IO timeout flag
//   state                         current FSM state encoding
module mem_io_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    input  logic              cpu_io_read,
    input  logic              cpu_io_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_rst,
    input  logic              upg_req,
    input  logic              upg_wen,
    input  logic [ADDR_W-1:0] upg_addr,
    input  logic [DATA_W-1:0] upg_wdata,
    input  logic              upg_done,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              io_req,
    output logic              io_we,
    output logic [7:0]        io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_ready,
    output logic [15:0]       load_count,
    output logic              io_err,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_IO_WAIT = 3'd1,
        S_IO_DONE = 3'd2,
        S_LOAD    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    // Last counter value seen in IO_WAIT before giving up: IO_WAIT lasts at most
    // TIMEOUT cycles, counter values 0 .. TIMEOUT-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                cpu_rst_q;
    logic                io_req_q;
    logic                io_we_q;
    logic [7:0]          io_addr_q;
    logic [DATA_W-1:0]   io_wdata_q;
    logic [DATA_W-1:0]   io_q;
    logic [15:0]         load_cnt_q;
    logic                io_err_q;
    logic [7:0]          tmo_cnt_q;

    logic io_acc;
    logic io_timeout;

    assign io_acc     = cpu_io_read | cpu_io_write;
    assign io_timeout = (state_q == S_IO_WAIT) && !io_ready && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                // Loader request outranks a new IO access in the same cycle.
                if (upg_req)     state_d = S_LOAD;
                else if (io_acc) state_d = S_IO_WAIT;
            end
            S_IO_WAIT: begin
                if (io_ready || io_timeout) state_d = S_IO_DONE;
            end
            S_IO_DONE: state_d = upg_req ? S_LOAD : S_RUN;
            S_LOAD: begin
                if (upg_done || !upg_req) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            cpu_rst_q  <= 1'b0;
            io_req_q   <= 1'b0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            io_q       <= '0;
            load_cnt_q <= '0;
            io_err_q   <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cpu_rst_q <= (state_d == S_LOAD) || (state_d == S_DRAIN);
            io_req_q  <= (state_d == S_IO_WAIT);

            if (state_q == S_RUN && !upg_req && io_acc) begin
                io_addr_q  <= cpu_addr[7:0];
                io_wdata_q <= cpu_wdata;
                io_we_q    <= cpu_io_write;
            end

            if (state_q == S_IO_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
                if (io_ready) begin
                    io_q <= io_rdata;
                end else if (io_timeout) begin
                    io_q     <= '0;
                    io_err_q <= 1'b1;
                end
            end else begin
                tmo_cnt_q <= '0;
            end

            if (state_q != S_LOAD && state_d == S_LOAD) begin
                load_cnt_q <= '0;
            end else if (state_q == S_LOAD && upg_wen && load_cnt_q != 16'hFFFF) begin
                load_cnt_q <= load_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wen   = 1'b0;
        cpu_stall = 1'b0;
        case (state_q)
            S_RUN: begin
                cpu_stall = upg_req | io_acc;
                // A stalled instruction does not retire, so it must not write.
                mem_wen   = cpu_mem_write & ~io_acc & ~upg_req;
            end
            S_IO_WAIT: cpu_stall = 1'b1;
            S_IO_DONE: cpu_stall = 1'b0;
            S_LOAD: begin
                cpu_stall = 1'b1;
                mem_wen   = upg_wen;
                mem_addr  = upg_addr;
                mem_wdata = upg_wdata;
            end
            S_DRAIN: cpu_stall = 1'b1;
            default: cpu_stall = 1'b0;
        endcase
    end

    // Outside IO_DONE the RAM data is only passed on for an actual load so a
    // non-load instruction never sees stale RAM contents.
    assign cpu_rdata  = (state_q == S_IO_DONE) ? io_q :
                        (cpu_mem_read ? mem_rdata : '0);
    assign cpu_rst    = cpu_rst_q;
    assign io_req     = io_req_q;
    assign io_we      = io_we_q;
    assign io_addr    = io_addr_q;
    assign io_wdata   = io_wdata_q;
    assign load_count = load_cnt_q;
    assign io_err     = io_err_q;
    assign state      = state_q;

endmodule

// File: doc/mem_io_arbiter.md
# mem_io_arbiter

Shares the single data-memory port and the peripheral bus between the CPU datapath and the UART program loader. It also sequences IO accesses through a ready handshake, so slow peripherals do not corrupt single-cycle execution. The block sits between the control/decode stage (which supplies MemRead/MemWrite/IORead/IOWrite) and the data RAM and IO peripherals. It stalls or holds the CPU in reset whenever the CPU does not own the shared resources.

## Interface
Parameters:
- ADDR_W, 14, data-memory word-address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum IO_WAIT cycles before abort (8-bit counter)

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- cpu_mem_read, cpu_mem_write  in  1 each  CPU memory strobes
- cpu_io_read, cpu_io_write  in  1 each  CPU IO strobes
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  load data returned to CPU
- cpu_stall  out  1  freezes PC/register-file write
- cpu_rst  out  1  holds CPU in reset
- upg_req  in  1  loader requests memory ownership
- upg_wen  in  1  loader write strobe
- upg_addr  in  ADDR_W  loader address
- upg_wdata  in  DATA_W  loader data
- upg_done  in  1  loader finished
- mem_wen  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- io_req, io_we  out  1 each  peripheral request / direction
- io_addr  out  8  = latched cpu_addr[7:0]
- io_wdata  out  DATA_W  latched store data
- io_rdata  in  DATA_W  peripheral read data
- io_ready  in  1  peripheral completion
- load_count  out  16  words written by loader, saturating
- io_err  out  1  sticky timeout flag
- state  out  3  RUN=0, IO_WAIT=1, IO_DONE=2, LOAD=3, DRAIN=4

## Operation
- RUN:
  - RAM port follows the CPU: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_wen=cpu_mem_write, cpu_rdata=mem_rdata.
  - upg_req=1 → LOAD. This has priority over a new IO access in the same cycle; cpu_stall=1 in that cycle.
  - cpu_io_read|cpu_io_write → cpu_stall=1 (combinational). On the same edge, latch io_addr/io_wdata/io_we; next state IO_WAIT.
- IO_WAIT:
  - io_req=1, cpu_stall=1, mem_wen=0; timeout counter increments each cycle.
  - io_ready=1 → capture io_rdata into io_q; go to IO_DONE.
  - Counter reaches TIMEOUT without io_ready → io_err:=1, io_q:=0, go to IO_DONE.
  - upg_req is ignored until IO_DONE completes.
- IO_DONE: one cycle with cpu_stall=0 and cpu_rdata=io_q, so the CPU retires the instruction. io_req=0. Next state is RUN, or LOAD if upg_req=1.
- LOAD:
  - cpu_rst=1, cpu_stall=1. RAM port follows the loader: mem_wen=upg_wen, mem_addr=upg_addr, mem_wdata=upg_wdata.
  - Each upg_wen increments load_count, saturating at 0xFFFF.
  - upg_done=1 or upg_req=0 → DRAIN. A write coincident with upg_done is still performed and counted.
- DRAIN: one cycle with cpu_rst=1 and mem_wen=0, then RUN. load_count holds until the next entry to LOAD, which clears it.
- io_err is cleared only by reset.

## Timing
- Reset values:
  - state=RUN; cpu_rst=0; io_req=0; io_we=0; io_addr=0; io_wdata=0; io_q=0; load_count=0; io_err=0; timeout counter=0.
  - Combinational outputs in reset follow RUN decoding.
- IO latency: minimum 3 cycles, strobe cycle + IO_WAIT + IO_DONE (io_ready asserted in the first IO_WAIT cycle). Maximum is TIMEOUT+2.
- io_ready is sampled only in IO_WAIT. io_ready outside IO_WAIT is ignored.
- Memory accesses in RUN are single-cycle with no stall.
- Load exit: cpu_rst deasserts 2 edges after upg_done is sampled (LOAD→DRAIN→RUN).
- Reset mid-transaction: io_req drops immediately (asynchronous), the FSM returns to RUN, and no partial RAM write is issued after reset asserts.
- Simultaneous cpu_mem_write and cpu_io_write: the IO path wins and mem_wen=0.

## Test plan
- IO read handshake: cpu_io_read, io_ready after 2 IO_WAIT cycles with io_rdata=0xA5A5_0001 → cpu_stall high 3 cycles, then in IO_DONE cpu_stall=0 and cpu_rdata=0xA5A5_0001.
- IO timeout: cpu_io_write, io_ready never asserted → after 255 IO_WAIT cycles io_err=1, IO_DONE with cpu_rdata=0; io_err stays 1 through later accesses.
- Program load: upg_req=1, 4 upg_wen writes to addresses 0..3, upg_done coincident with the 4th write → 4 RAM writes, load_count=4, cpu_rst high through DRAIN, RUN 2 cycles after upg_done.
- Contention: upg_req rises during IO_WAIT → LOAD entered only after IO_DONE; the IO transaction completes intact.
- Plain memory: cpu_mem_write to 0x0010 with data 0x1234_5678, then cpu_mem_read → no stall; mem_wen=1 for exactly one cycle.
- Async reset: assert reset in IO_WAIT and in LOAD → state=RUN, io_req=0, cpu_rst=0, load_count=0 with no clock edge required.
